player_cmd_issuer: RTL and testbench
====================================

# player_cmd_issuer

Producer side of the 16-bit player instruction bus. It collects game events (heal, damage, attack changes, HP set), movement requests and a restart request, and serialises them onto one registered `instruction` word. The word format is {opcode[3:0], operand[7:0], 4'b0000}, and the idle word is 0x0000 (NOP). It sits between the game-logic/input decoders and the player block, one instruction per clock.

## Interface
- `DEPTH`, 4: event FIFO depth, power of two, 2..16.
- `RESTART_HP`, 100: operand of the HP-set word issued on restart.
- `RESTART_ATK`, 10: operand of the ATK-set word issued on restart.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ev_valid`  in  1  event offered.
- `ev_op`  in  4  event opcode. Legal values: 0001 heal, 0010 damage, 0011 ATK add, 0100 ATK set, 0110 HP set.
- `ev_arg`  in  8  event operand.
- `ev_ready`  out  1  event accepted at any edge where `ev_valid` && `ev_ready`.
- `move_valid`  in  1  movement request.
- `move_dir`  in  2  0 left, 1 up, 2 right, 3 down.
- `tick`  in  1  one-cycle pulse from the 10 Hz divider; move slot.
- `restart`  in  1  one-cycle pulse; reload player defaults.
- `instruction`  out  16  registered instruction word.
- `issued`  out  1  registered; high the cycle `instruction` holds a non-NOP word.
- `err_op`  out  1  registered one-cycle pulse; an illegal opcode was accepted and dropped.
- `fifo_count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Reset (`rst_n`=0 at an edge):**
  - `instruction`=0x0000, `issued`=0, `err_op`=0.
  - FIFO empty, `fifo_count`=0, move-pending cleared, FSM in IDLE.
  - `ev_ready` is forced 0 while `rst_n`=0.
- **`ev_ready`:** combinational; equals (state==IDLE) && !`restart` && `fifo_count`<DEPTH. There is no pop-through when full, so a full FIFO holds `ev_ready`=0 even in a cycle that pops.
- **Accepted events:**
  - Legal opcodes are pushed as {ev_op, ev_arg}.
  - Illegal opcodes (0000, 0101, 0111–1111) are not pushed; `err_op`=1 on the next cycle.
- **Move register:** single entry, written whenever `move_valid`=1. Latest direction wins; it overwrites any pending move.
- **FSM states:** IDLE, RST_HP, RST_ATK.
- **Per-edge instruction selection, in priority order:**
  1. `restart`=1 (any state):
     - FIFO flushed, move-pending cleared, `move_valid` in the same cycle ignored.
     - `instruction` <= {0110, RESTART_HP, 0000} (default 0x6640); state <= RST_ATK.
  2. State RST_ATK: `instruction` <= {0100, RESTART_ATK, 0000} (default 0x40A0); state <= IDLE.
  3. `tick`=1 and move pending:
     - `instruction` <= {0101, 6'b0, dir, 0000}, e.g. right = 0x5020.
     - Move-pending is cleared, unless `move_valid`=1 in the same cycle, in which case the new request stays pending.
     - No FIFO pop this cycle.
  4. FIFO non-empty: pop the head; `instruction` <= {op, arg, 0000}.
  5. Otherwise `instruction` <= 0x0000.
- **RST_HP:** this encoding is reserved. The restart entry goes directly to RST_ATK after the HP word, so the FSM never occupies RST_HP. An implementation that reaches RST_HP returns to IDLE and outputs NOP.
- **One-cycle words:** every non-NOP word is held exactly one cycle. Heal/damage must never repeat on consecutive cycles unless two events were queued.
- **`fifo_count`:** push and pop in the same edge leaves the count unchanged. Pointers wrap modulo DEPTH.
- **`issued`:** equals (next `instruction` != 0), registered alongside `instruction`.

## Timing
- Event accepted at edge N with FIFO empty and no tick/restart at N+1: the word appears on `instruction` after edge N+1 (2-edge latency).
- Move: the word appears after the first edge with `tick`=1 at or after the edge that latched the request. It shares that edge if `move_valid` and `tick` are both high.
- A tick with nothing pending does not stall the FIFO.
- Restart sampled at edge R:
  - 0x6640 after R, 0x40A0 after R+1.
  - `ev_ready`=0 during cycles R and R+1; normal issue resumes from edge R+2.
  - A second restart at R+1 restarts the sequence: 0x6640 again.
- Reset mid-sequence or with the FIFO full: everything returns to reset values at that edge. Nothing queued before reset is ever issued.

## Test plan
- **Basic event:** after reset, push damage arg 0x0C -> exactly one cycle of 0x20C0 two edges later with `issued`=1, then 0x0000.
- **Fill and drain:** push 4 heals with arg 1..4 back-to-back -> `ev_ready`=0 at count 4; output 0x1010, 0x1020, 0x1030, 0x1040 on consecutive cycles; count returns to 0.
- **Move preempts FIFO:** FIFO holds 2 events; `move_valid` dir=3, then `tick` -> 0x5030 in the tick cycle; the FIFO words follow unchanged in order, one cycle delayed.
- **Latest move wins:** dirs 0 then 2 before a tick -> a single 0x5020 at the tick. A second tick with no new request -> NOP.
- **Illegal opcode:** `ev_op`=0101 accepted -> `err_op` pulse next cycle, no push, `instruction` stays 0x0000.
- **Restart:** `restart` with FIFO full and a move pending -> 0x6640, then 0x40A0, then NOP; `fifo_count`=0; `ev_ready` low for 2 cycles. Repeat with `rst_n` low during the 0x40A0 cycle -> outputs at reset values on the next edge.

Source files
------------

// File: rtl/player_cmd_issuer.sv
// Producer for the 16-bit player instruction bus: queues game events, holds one pending
// move, and serialises restart / move / event words onto a registered instruction port.
module player_cmd_issuer #(
   parameter int DEPTH       = 4,
   parameter int RESTART_HP  = 100,
   parameter int RESTART_ATK = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ev_valid,
   input  logic [3:0]               ev_op,
   input  logic [7:0]               ev_arg,
   output logic                     ev_ready,
   input  logic                     move_valid,
   input  logic [1:0]               move_dir,
   input  logic                     tick,
   input  logic                     restart,
   output logic [15:0]              instruction,
   output logic                     issued,
   output logic                     err_op,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [1:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [7:0] LP_HP  = 8'(RESTART_HP);
   localparam logic [7:0] LP_ATK = 8'(RESTART_ATK);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RST_HP  = 2'd1,
      S_RST_ATK = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [11:0]       r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic              r_mv_pend;
   logic [1:0]        r_mv_dir;

   logic [15:0]       r_instr;
   logic              r_issued;
   logic              r_err_op;

   logic              w_legal;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_move_issue;
   logic [1:0]        w_issue_dir;
   logic [15:0]       w_instr_nxt;

   always_comb begin
      case (ev_op)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h6: w_legal = 1'b1;
         default:                      w_legal = 1'b0;
      endcase
   end

   // No pop-through: a full FIFO refuses events even in a cycle that pops.
   assign ev_ready = rst_n && (r_state == S_IDLE) && !restart && (r_count < CW'(DEPTH));
   assign w_accept = ev_valid && ev_ready;
   assign w_push   = w_accept && w_legal;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = S_IDLE;
      if (restart) begin
         w_state_nxt = S_RST_ATK;
      end else begin
         case (r_state)
            S_IDLE:    w_state_nxt = S_IDLE;
            S_RST_ATK: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
         endcase
      end
   end

   // A move issued at a tick uses the pending direction if one exists; otherwise a
   // request arriving with the tick is served immediately.
   always_comb begin
      w_instr_nxt  = 16'h0000;
      w_pop        = 1'b0;
      w_flush      = 1'b0;
      w_move_issue = 1'b0;
      w_issue_dir  = r_mv_pend ? r_mv_dir : move_dir;
      if (restart) begin
         w_flush     = 1'b1;
         w_instr_nxt = {4'h6, LP_HP, 4'h0};
      end else if (r_state == S_RST_ATK) begin
         w_instr_nxt = {4'h4, LP_ATK, 4'h0};
      end else if (r_state == S_RST_HP) begin
         w_instr_nxt = 16'h0000;
      end else if (tick && (r_mv_pend || move_valid)) begin
         w_move_issue = 1'b1;
         w_instr_nxt  = {4'h5, 6'b0, w_issue_dir, 4'h0};
      end else if (r_count != '0) begin
         w_pop       = 1'b1;
         w_instr_nxt = {r_mem[r_rd_ptr], 4'h0};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {ev_op, ev_arg};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || w_flush) begin
         r_mv_pend <= 1'b0;
         r_mv_dir  <= 2'd0;
      end else if (w_move_issue) begin
         if (r_mv_pend && move_valid) begin
            r_mv_pend <= 1'b1;
            r_mv_dir  <= move_dir;
         end else begin
            r_mv_pend <= 1'b0;
         end
      end else if (move_valid) begin
         r_mv_pend <= 1'b1;
         r_mv_dir  <= move_dir;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_instr  <= 16'h0000;
         r_issued <= 1'b0;
         r_err_op <= 1'b0;
      end else begin
         r_instr  <= w_instr_nxt;
         r_issued <= (w_instr_nxt != 16'h0000);
         r_err_op <= w_accept && !w_legal;
      end
   end

   assign instruction = r_instr;
   assign issued      = r_issued;
   assign err_op      = r_err_op;
   assign fifo_count  = r_count;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_player_cmd_issuer.sv
// Bench for player_cmd_issuer: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the instruction-selection rules.
module tb_player_cmd_issuer;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ev_valid = 1'b0;
   logic [3:0]    ev_op = '0;
   logic [7:0]    ev_arg = '0;
   logic          ev_ready;
   logic          move_valid = 1'b0;
   logic [1:0]    move_dir = '0;
   logic          tick = 1'b0;
   logic          restart = 1'b0;
   logic [15:0]   instruction;
   logic          issued;
   logic          err_op;
   logic [CW-1:0] fifo_count;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   player_cmd_issuer #(.DEPTH(DEPTH), .RESTART_HP(100), .RESTART_ATK(10)) dut (
      .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_op(ev_op), .ev_arg(ev_arg),
      .ev_ready(ev_ready), .move_valid(move_valid), .move_dir(move_dir), .tick(tick),
      .restart(restart), .instruction(instruction), .issued(issued), .err_op(err_op),
      .fifo_count(fifo_count), .dbg_state(dbg_state)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: event queue, one pending move, restart phase flag.
   logic [11:0] exp_q[$];
   bit          m_pend = 0;
   logic [1:0]  m_dir = '0;
   bit          m_atk_next = 0;
   logic [15:0] m_instr = '0;
   bit          m_err = 0;

   task automatic cycle(input bit rn, input bit ev, input logic [3:0] op, input logic [7:0] arg,
                        input bit mv, input logic [1:0] d, input bit tk, input bit rs);
      bit rdy, acc, legal, moved;
      @(negedge clk);
      rst_n = rn; ev_valid = ev; ev_op = op; ev_arg = arg;
      move_valid = mv; move_dir = d; tick = tk; restart = rs;
      #1;
      rdy = rn && !m_atk_next && !rs && (exp_q.size() < DEPTH);
      check_eq("ev_ready", 16'(ev_ready), 16'(rdy));
      acc   = ev && rdy;
      legal = op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
      if (!rn) begin
         exp_q.delete(); m_pend = 0; m_atk_next = 0; m_instr = 16'h0000; m_err = 0;
      end else begin
         m_err = acc && !legal;
         moved = 0;
         if (rs) begin
            exp_q.delete(); m_pend = 0; m_atk_next = 1; m_instr = 16'h6640;
            moved = 1;
         end else if (m_atk_next) begin
            m_atk_next = 0; m_instr = 16'h40A0;
         end else if (tk && m_pend) begin
            m_instr = {4'h5, 6'b0, m_dir, 4'h0};
            m_pend = mv;
            if (mv) m_dir = d;
            moved = 1;
         end else if (tk && mv) begin
            m_instr = {4'h5, 6'b0, d, 4'h0};
            moved = 1;
         end else if (exp_q.size() > 0) begin
            m_instr = {exp_q.pop_front(), 4'h0};
         end else begin
            m_instr = 16'h0000;
         end
         if (!moved && mv) begin
            m_pend = 1; m_dir = d;
         end
         if (acc && legal) exp_q.push_back({op, arg});
      end
      @(posedge clk);
      #1;
      check_eq("instruction", instruction, m_instr);
      check_eq("issued", 16'(issued), 16'(m_instr != 16'h0000));
      check_eq("err_op", 16'(err_op), 16'(m_err));
      check_eq("fifo_count", 16'(fifo_count), 16'(exp_q.size()));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 4'h0, 8'h00, 0, 2'd0, 0, 0);
   endtask

   task automatic fill_with_pending_move();
      cycle(1, 0, 4'h0, 8'h00, 1, 2'd1, 0, 0);
      for (int i = 1; i <= 4; i++) cycle(1, 1, 4'h1, 8'(i), 1, 2'd3, 1, 0);
   endtask

   initial begin
      // reset
      cycle(0, 0, 4'h0, 8'h00, 0, 2'd0, 0, 0);
      cycle(0, 1, 4'h2, 8'h55, 1, 2'd2, 1, 1);
      check_eq("reset_instr", instruction, 16'h0000);
      check_eq("reset_count", 16'(fifo_count), 16'h0000);

      // basic damage event: 0x20C0 two edges after accept
      cycle(1, 1, 4'h2, 8'h0C, 0, 2'd0, 0, 0);
      cycle(1, 0, 4'h0, 8'h00, 0, 2'd0, 0, 0);
      check_eq("basic_word", instruction, 16'h20C0);
      idle(2);

      // fill while moves hold the slot, then drain heals 1..4
      for (int i = 1; i <= 5; i++) cycle(1, 1, 4'h1, 8'(i), 1, 2'd0, 1, 0);
      check_eq("full_count", 16'(fifo_count), 16'(DEPTH));
      idle(1);
      check_eq("drain_first", instruction, 16'h1010);
      idle(4);

      // move preempts queued events
      cycle(1, 1, 4'h3, 8'h21, 1, 2'd0, 1, 0);
      cycle(1, 1, 4'h4, 8'h22, 1, 2'd3, 1, 0);
      cycle(1, 0, 4'h0, 8'h00, 1, 2'd3, 1, 0);
      idle(4);

      // latest move wins, second tick is NOP
      cycle(1, 0, 4'h0, 8'h00, 1, 2'd0, 0, 0);
      cycle(1, 0, 4'h0, 8'h00, 1, 2'd2, 0, 0);
      cycle(1, 0, 4'h0, 8'h00, 0, 2'd0, 1, 0);
      check_eq("latest_move", instruction, 16'h5020);
      cycle(1, 0, 4'h0, 8'h00, 0, 2'd0, 1, 0);

      // illegal opcode
      cycle(1, 1, 4'h5, 8'hAA, 0, 2'd0, 0, 0);
      cycle(1, 0, 4'h0, 8'h00, 0, 2'd0, 0, 0);

      // restart with full FIFO and a move pending
      fill_with_pending_move();
      cycle(1, 0, 4'h0, 8'h00, 1, 2'd2, 1, 1);
      check_eq("restart_hp", instruction, 16'h6640);
      idle(2);
      // double restart
      cycle(1, 0, 4'h0, 8'h00, 0, 2'd0, 0, 1);
      cycle(1, 0, 4'h0, 8'h00, 0, 2'd0, 0, 1);
      idle(3);
      // reset during the ATK word cycle
      fill_with_pending_move();
      cycle(1, 0, 4'h0, 8'h00, 0, 2'd0, 0, 1);
      cycle(0, 0, 4'h0, 8'h00, 0, 2'd0, 0, 0);
      idle(3);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 6),
               4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
               ($urandom_range(0, 99) < 15), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 99) < 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
